// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for seven-segment display blocks.
//   SEG_OFF    : all segments dark (active-high internal form gfedcba)
//   SEG_MINUS  : only segment g lit
//   HEX_SEG    : 16-entry hex-to-segment table, active-high, index = nibble
//   idx_width  : bit width of a digit index counter for a given digit count
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_OFF   = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;

  // Element 0 is listed first; bit order is {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111,  // 9
    7'b1110111,  // A
    7'b1111100,  // b
    7'b0111001,  // C
    7'b1011110,  // d
    7'b1111001,  // E
    7'b1110001   // F
  };

  // A one-bit counter is still needed for two digits, so clamp at 1.
  function automatic int idx_width(input int digits);
    return (digits <= 2) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational hex nibble to seven-segment decoder (active-high output).
// Ports:
//   nibble : in  [3:0] hex digit to display
//   seg    : out [6:0] segments {g,f,e,d,c,b,a}, 1 = lit
// ---------------------------------------------------------------------------
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scanner.sv
// ---------------------------------------------------------------------------
// seg7_scanner
// Time-multiplexed seven-segment display driver. Each rising edge of
// scan_clk (sampled as data in the clk domain) advances the lit digit.
// All display outputs are registered.
// Parameters:
//   DIGITS     : number of multiplexed digits (2..8)
//   ACTIVE_LOW : 1 = anode/seg/dp low-active, 0 = high-active
// Ports:
//   clk       : in  system clock
//   rst       : in  asynchronous active-high reset
//   scan_clk  : in  divided scan clock, synchronous to clk, used as data
//   value     : in  [4*DIGITS-1:0] hex nibbles, digit 0 rightmost
//   blank     : in  [DIGITS-1:0] 1 = digit dark
//   neg       : in  leftmost digit shows a minus sign
//   anode     : out [DIGITS-1:0] digit enables, at most one active
//   seg       : out [6:0] cathodes {g,f,e,d,c,b,a}
//   dp        : out decimal point, always inactive
//   digit_idx : out [2:0] current scan index
// ---------------------------------------------------------------------------
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_clk,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  neg,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [2:0]            digit_idx
);

  localparam int IDX_W = idx_width(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  // XOR masks applied at the register input to get the pin polarity.
  localparam logic [DIGITS-1:0] ANODE_POL = {DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]        SEG_POL   = {7{ACTIVE_LOW}};

  // -------------------------------------------------------------------------
  // Edge detect on scan_clk: only rising edges advance the scan.
  // -------------------------------------------------------------------------
  logic scan_q_reg;
  logic step;

  assign step = scan_clk & ~scan_q_reg;

  // -------------------------------------------------------------------------
  // Digit index counter, wraps at DIGITS-1.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] idx_next;

  always_comb begin
    idx_next = idx_reg;
    if (step) begin
      idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q_reg <= 1'b0;
      idx_reg    <= '0;
    end else begin
      scan_q_reg <= scan_clk;
      idx_reg    <= idx_next;
    end
  end

  assign digit_idx = 3'(idx_reg);

  // -------------------------------------------------------------------------
  // Digit select. An index that does not map to a digit is treated as
  // blank, so no anode can ever light for it.
  // -------------------------------------------------------------------------
  logic [3:0] nibble_sel;
  logic       digit_blank;

  always_comb begin
    nibble_sel  = 4'h0;
    digit_blank = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        nibble_sel  = value[4*i +: 4];
        digit_blank = blank[i];
      end
    end
  end

  logic [6:0] dec_seg;

  seg7_decode u_decode (
    .nibble (nibble_sel),
    .seg    (dec_seg)
  );

  // Active-high segment pattern for the selected digit.
  logic [6:0] seg_hi;

  always_comb begin
    if (digit_blank) begin
      seg_hi = SEG_OFF;
    end else if (neg && (idx_reg == LAST_IDX)) begin
      seg_hi = SEG_MINUS;
    end else begin
      seg_hi = dec_seg;
    end
  end

  // Active-high one-hot anode; all zero when the digit is blanked.
  logic [DIGITS-1:0] anode_hi;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_anode
      assign anode_hi[gi] = ~digit_blank & (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Output registers with polarity applied. Reset values are the inactive
  // level for the chosen polarity, so the display goes dark immediately.
  // -------------------------------------------------------------------------
  logic [DIGITS-1:0] anode_reg;
  logic [6:0]        seg_reg;
  logic              dp_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_reg <= ANODE_POL;
      seg_reg   <= SEG_OFF ^ SEG_POL;
      dp_reg    <= ACTIVE_LOW;
    end else begin
      anode_reg <= anode_hi ^ ANODE_POL;
      seg_reg   <= seg_hi ^ SEG_POL;
      dp_reg    <= ACTIVE_LOW;
    end
  end

  assign anode = anode_reg;
  assign seg   = seg_reg;
  assign dp    = dp_reg;

endmodule
